// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: Moore sequencer, ALU decode, NZCV flag register
// and condition check that gates the architectural writes of each instruction.
module multicycle_control #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [3:0] flags;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       pcs;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: c.alu_src_b = 2'b01;
            MEMRD:  c.adr_src = 1'b1;
            MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            EXECR: c.alu_op = 1'b1;
            EXECI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            ALUWB: c.reg_w = 1'b1;
            BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    // Controls are registered from the next state so every output is glitch-free per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state);
        end
    end

    always_comb begin
        ALUControl = 2'b00;
        flag_w     = 2'b00;
        if (ctrl.alu_op) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = 2'b00; flag_w = {2{Funct[0]}}; end
                4'b0010: begin ALUControl = 2'b01; flag_w = {2{Funct[0]}}; end
                4'b0000: begin ALUControl = 2'b10; flag_w = {Funct[0], 1'b0}; end
                4'b1100: begin ALUControl = 2'b11; flag_w = {Funct[0], 1'b0}; end
                default: begin ALUControl = 2'b00; flag_w = 2'b00; end
            endcase
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = !flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = !flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = !flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = !flags[0];
            4'b1000: cond_ex = flags[1] && !flags[2];
            4'b1001: cond_ex = !flags[1] || flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NZ and CV halves update independently so logical ops keep the previous carry/overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= RESET_FLAGS;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs       = ctrl.branch | (ctrl.reg_w & (Rd == 4'd15));
    assign PCWrite   = ctrl.next_pc | (pcs & cond_ex);
    assign RegWrite  = ctrl.reg_w & cond_ex;
    assign MemWrite  = ctrl.mem_w & cond_ex;
    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// and infers the flag register contents through conditional branches.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Cond = 4'b0;
    logic [1:0] Op = 2'b0;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic [3:0] ALUFlags = 4'b0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_control #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o,
                                 input logic [5:0] f, input logic [3:0] r,
                                 input logic [3:0] af);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs a branch with the given condition and returns to FETCH; PCWrite in BRANCH reveals CondEx.
    task automatic probeBranch(input string tag, input logic [3:0] c, input logic exp_pc);
        applyStimulus(c, 2'b10, 6'b000000, 4'd0, 4'b0000);
        tick();
        tick();
        checkOutput(tag, {3'b0, PCWrite}, {3'b0, exp_pc});
        tick();
    endtask

    initial begin
        applyStimulus(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
        tick();
        tick();
        checkOutput("rst_irwrite", {3'b0, IRWrite}, 4'd1);
        checkOutput("rst_pcwrite", {3'b0, PCWrite}, 4'd1);
        checkOutput("rst_regwrite", {3'b0, RegWrite}, 4'd0);
        reset = 1'b1;
        checkOutput("fetch_alusrcb", {2'b0, ALUSrcB}, 4'd2);
        checkOutput("fetch_alusrca", {3'b0, ALUSrcA}, 4'd1);
        checkOutput("fetch_resultsrc", {2'b0, ResultSrc}, 4'd2);

        // Flags cleared by reset: EQ fails, NE passes.
        probeBranch("beq_z0", 4'b0000, 1'b0);
        probeBranch("bne_z0", 4'b0001, 1'b1);

        // ADDS R1,R2,R3
        applyStimulus(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110);
        tick();
        checkOutput("adds_dec_irwrite", {3'b0, IRWrite}, 4'd0);
        checkOutput("adds_dec_pcwrite", {3'b0, PCWrite}, 4'd0);
        tick();
        checkOutput("adds_execr_aluctl", {2'b0, ALUControl}, 4'd0);
        checkOutput("adds_execr_alusrcb", {2'b0, ALUSrcB}, 4'd0);
        checkOutput("adds_execr_regwrite", {3'b0, RegWrite}, 4'd0);
        tick();
        checkOutput("adds_aluwb_regwrite", {3'b0, RegWrite}, 4'd1);
        checkOutput("adds_aluwb_resultsrc", {2'b0, ResultSrc}, 4'd0);
        checkOutput("adds_aluwb_pcwrite", {3'b0, PCWrite}, 4'd0);
        tick();
        checkOutput("adds_back_fetch", {3'b0, IRWrite}, 4'd1);

        // Flags now 0110: BEQ taken.
        applyStimulus(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        tick();
        checkOutput("beq_dec_immsrc", {2'b0, ImmSrc}, 4'd2);
        checkOutput("beq_dec_regsrc", {2'b0, RegSrc}, 4'd1);
        tick();
        checkOutput("beq_z1_pcwrite", {3'b0, PCWrite}, 4'd1);
        checkOutput("beq_z1_alusrcb", {2'b0, ALUSrcB}, 4'd1);
        checkOutput("beq_z1_resultsrc", {2'b0, ResultSrc}, 4'd2);
        tick();
        checkOutput("beq_back_fetch", {3'b0, IRWrite}, 4'd1);

        // ORRS with ALUFlags=1011: NZ <- 10, CV kept at 10 -> flags 1010.
        applyStimulus(4'b1110, 2'b00, 6'b011001, 4'd4, 4'b1011);
        tick();
        tick();
        checkOutput("orrs_execr_aluctl", {2'b0, ALUControl}, 4'd3);
        tick();
        tick();
        probeBranch("bmi_after_orrs", 4'b0100, 1'b1);
        probeBranch("beq_after_orrs", 4'b0000, 1'b0);
        probeBranch("bvs_after_orrs", 4'b0110, 1'b0);
        probeBranch("bcs_after_orrs", 4'b0010, 1'b1);
        probeBranch("bhi_after_orrs", 4'b1000, 1'b1);

        // LDR R2,[R3,#imm]
        applyStimulus(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        tick();
        checkOutput("ldr_dec_regsrc", {2'b0, RegSrc}, 4'd2);
        tick();
        checkOutput("ldr_memadr_alusrcb", {2'b0, ALUSrcB}, 4'd1);
        checkOutput("ldr_memadr_alusrca", {3'b0, ALUSrcA}, 4'd0);
        tick();
        checkOutput("ldr_memrd_adrsrc", {3'b0, AdrSrc}, 4'd1);
        checkOutput("ldr_memrd_regwrite", {3'b0, RegWrite}, 4'd0);
        tick();
        checkOutput("ldr_memwb_resultsrc", {2'b0, ResultSrc}, 4'd1);
        checkOutput("ldr_memwb_regwrite", {3'b0, RegWrite}, 4'd1);
        tick();
        checkOutput("ldr_back_fetch", {3'b0, IRWrite}, 4'd1);

        // STR
        applyStimulus(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
        tick();
        checkOutput("str_dec_memwrite", {3'b0, MemWrite}, 4'd0);
        tick();
        checkOutput("str_memadr_memwrite", {3'b0, MemWrite}, 4'd0);
        tick();
        checkOutput("str_memwr_memwrite", {3'b0, MemWrite}, 4'd1);
        checkOutput("str_memwr_adrsrc", {3'b0, AdrSrc}, 4'd1);
        tick();
        checkOutput("str_fetch_memwrite", {3'b0, MemWrite}, 4'd0);
        checkOutput("str_back_fetch", {3'b0, IRWrite}, 4'd1);

        // SUB PC,... with AL
        applyStimulus(4'b1110, 2'b00, 6'b000100, 4'd15, 4'b0000);
        tick();
        tick();
        checkOutput("sub_execr_aluctl", {2'b0, ALUControl}, 4'd1);
        tick();
        checkOutput("sub_pc_pcwrite", {3'b0, PCWrite}, 4'd1);
        checkOutput("sub_pc_regwrite", {3'b0, RegWrite}, 4'd1);
        tick();

        // Same instruction, condition 1111: no writes, same length.
        applyStimulus(4'b1111, 2'b00, 6'b000100, 4'd15, 4'b0000);
        tick();
        checkOutput("subnv_dec_pcwrite", {3'b0, PCWrite}, 4'd0);
        tick();
        checkOutput("subnv_execr_regwrite", {3'b0, RegWrite}, 4'd0);
        tick();
        checkOutput("subnv_aluwb_regwrite", {3'b0, RegWrite}, 4'd0);
        checkOutput("subnv_aluwb_pcwrite", {3'b0, PCWrite}, 4'd0);
        checkOutput("subnv_aluwb_memwrite", {3'b0, MemWrite}, 4'd0);
        tick();
        checkOutput("subnv_back_fetch", {3'b0, IRWrite}, 4'd1);

        // AND immediate through EXECI
        applyStimulus(4'b1110, 2'b00, 6'b100000, 4'd5, 4'b0000);
        tick();
        tick();
        checkOutput("and_execi_aluctl", {2'b0, ALUControl}, 4'd2);
        checkOutput("and_execi_alusrcb", {2'b0, ALUSrcB}, 4'd1);
        tick();
        checkOutput("and_aluwb_regwrite", {3'b0, RegWrite}, 4'd1);
        tick();

        // Undefined op class
        applyStimulus(4'b1110, 2'b11, 6'b000000, 4'd15, 4'b0000);
        tick();
        tick();
        checkOutput("unk_pcwrite", {3'b0, PCWrite}, 4'd0);
        checkOutput("unk_regwrite", {3'b0, RegWrite}, 4'd0);
        checkOutput("unk_irwrite", {3'b0, IRWrite}, 4'd0);
        tick();
        checkOutput("unk_back_fetch", {3'b0, IRWrite}, 4'd1);

        // Reset during EXECR abandons the instruction.
        applyStimulus(4'b1110, 2'b00, 6'b001000, 4'd3, 4'b0000);
        tick();
        tick();
        reset = 1'b0;
        #2;
        checkOutput("midrst_irwrite", {3'b0, IRWrite}, 4'd1);
        checkOutput("midrst_aluctl_alusrcb", {2'b0, ALUSrcB}, 4'd2);
        reset = 1'b1;
        tick();
        checkOutput("midrst_regwrite", {3'b0, RegWrite}, 4'd0);
        checkOutput("midrst_decode_irwrite", {3'b0, IRWrite}, 4'd0);
        tick();
        checkOutput("midrst_execr_aluctl", {2'b0, ALUControl}, 4'd0);
        tick();
        tick();

        // Flags cleared by the mid-instruction reset.
        probeBranch("bmi_after_rst", 4'b0100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
